// File: rtl/and_inputs_stim_pkg.sv
// Shared types and constants for the AND-gate input stimulus driver.
// The request/response structs are the default-width views of the transactions.
package and_inputs_stim_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_HOLD_W = 4;
  localparam logic [15:0] MISMATCH_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]  a;
    logic [DEF_WIDTH-1:0]  b;
    logic [DEF_HOLD_W-1:0] hold;
  } req_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_WIDTH-1:0] y;
    logic                 mismatch;
  } rsp_t;

endpackage

// File: rtl/and_inputs_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module and_inputs_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; entries are only visible through the pointers.
  always_ff @(posedge clock) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/and_inputs_stim_driver.sv
// Drives queued operand pairs onto the AND gate pins, holds them for
// SETTLE+hold cycles, then samples y and returns a checked response.
module and_inputs_stim_driver
  import and_inputs_stim_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WIDTH-1:0]  req_a,
  input  logic [WIDTH-1:0]  req_b,
  input  logic [HOLD_W-1:0] req_hold,
  output logic [WIDTH-1:0]  dut_a,
  output logic [WIDTH-1:0]  dut_b,
  input  logic [WIDTH-1:0]  dut_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_a,
  output logic [WIDTH-1:0]  rsp_b,
  output logic [WIDTH-1:0]  rsp_y,
  output logic              rsp_mismatch,
  output logic              busy,
  output logic [15:0]       mismatch_count,
  output state_e            state_dbg
);

  localparam int REQ_W = 2 * WIDTH + HOLD_W;
  localparam int CNT_W = HOLD_W + 1;

  // Handshakes: a transfer happens on the edge where valid && ready; valid
  // and its payload stay stable until then, and ready never depends on valid.
  state_e             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_load;
  logic [REQ_W-1:0]   fifo_rd;
  logic               fifo_full, fifo_empty;
  logic               pop, capture, mm_now;

  and_inputs_sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (req_valid && req_ready),
    .wr_data ({req_a, req_b, req_hold}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign req_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  assign state_dbg = state;
  assign cnt_load  = CNT_W'(SETTLE - 1) + CNT_W'(fifo_rd[HOLD_W-1:0]);
  assign mm_now    = (dut_y != (dut_a & dut_b));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop        = 1'b1;
        state_next = DRIVE;
      end
      DRIVE: if (cnt == '0) begin
        capture    = 1'b1;
        state_next = RESPOND;
      end
      RESPOND: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drive registers keep their last value between transactions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dut_a <= '0;
      dut_b <= '0;
      cnt   <= '0;
    end else if (pop) begin
      dut_a <= fifo_rd[REQ_W-1 -: WIDTH];
      dut_b <= fifo_rd[REQ_W-1-WIDTH -: WIDTH];
      cnt   <= cnt_load;
    end else if (state == DRIVE && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid      <= 1'b0;
      rsp_a          <= '0;
      rsp_b          <= '0;
      rsp_y          <= '0;
      rsp_mismatch   <= 1'b0;
      mismatch_count <= '0;
    end else if (capture) begin
      rsp_valid    <= 1'b1;
      rsp_a        <= dut_a;
      rsp_b        <= dut_b;
      rsp_y        <= dut_y;
      rsp_mismatch <= mm_now;
      if (mm_now && mismatch_count != MISMATCH_MAX) mismatch_count <= mismatch_count + 16'd1;
    end else if (state == RESPOND && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_and_inputs_stim_driver.sv
// Directed and randomized checks of the AND-gate stimulus driver against a
// transaction-level model of the gate and the expected responses.
module tb_and_inputs_stim_driver;
  import and_inputs_stim_pkg::*;

  localparam int W = 4;
  localparam int DEPTH = 4;
  localparam int SETTLE = 1;
  localparam int HOLD_W = 4;
  localparam int EW = 3 * W + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid, req_ready;
  logic [W-1:0]      req_a, req_b;
  logic [HOLD_W-1:0] req_hold;
  logic [W-1:0]      dut_a, dut_b, dut_y;
  logic              rsp_valid, rsp_ready;
  logic [W-1:0]      rsp_a, rsp_b, rsp_y;
  logic              rsp_mismatch, busy;
  logic [15:0]       mismatch_count;
  state_e            state_dbg;

  int checks = 0;
  int failures = 0;
  int mode = 0;  // gate model: 0 ideal AND, 1 stuck-at-0, 2 MSB behaves as OR
  logic [15:0] exp_count = '0;
  logic [EW-1:0] exp_q[$];  // {a, b, y, mismatch} in response order

  and_inputs_stim_driver #(.WIDTH(W), .DEPTH(DEPTH), .SETTLE(SETTLE), .HOLD_W(HOLD_W)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_hold(req_hold), .dut_a(dut_a), .dut_b(dut_b),
    .dut_y(dut_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_a(rsp_a),
    .rsp_b(rsp_b), .rsp_y(rsp_y), .rsp_mismatch(rsp_mismatch), .busy(busy),
    .mismatch_count(mismatch_count), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] gate_y(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
    logic [W-1:0] msb_or;
    msb_or = '0;
    msb_or[W-1] = a[W-1] | b[W-1];
    case (m)
      1:       return '0;
      2:       return (a & b) | msb_or;
      default: return a & b;
    endcase
  endfunction

  always_comb dut_y = gate_y(dut_a, dut_b, mode);

  function automatic logic [EW-1:0] make_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] y;
    logic mm;
    y  = gate_y(a, b, mode);
    mm = (y != (a & b));
    if (mm && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    return {a, b, y, mm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [HOLD_W-1:0] h);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_a = a; req_b = b; req_hold = h;
    while (!req_ready && guard < 200) begin step(); guard++; end
    chk("push_wait", 32'(guard < 200), 32'd1);
    exp_q.push_back(make_exp(a, b));
    step();
    req_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
    chk({tag, "_a"}, 32'(rsp_a), 32'(e[3*W -: W]));
    chk({tag, "_b"}, 32'(rsp_b), 32'(e[2*W -: W]));
    chk({tag, "_y"}, 32'(rsp_y), 32'(e[W -: W]));
    chk({tag, "_mm"}, 32'(rsp_mismatch), 32'(e[0]));
  endtask

  task automatic get_rsp(input string tag);
    int guard;
    guard = 0;
    while (!rsp_valid && guard < 200) begin step(); guard++; end
    chk({tag, "_timeout"}, 32'(guard < 200), 32'd1);
    check_rsp(tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int bad, pushed, accepted;
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_hold = '0; rsp_ready = 1'b0;
    step(2);
    reset = 1'b0;
    step();
    chk("rst_dut_a", 32'(dut_a), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(mismatch_count), 0);

    // single transaction timing
    push(4'h1, 4'h1, 4'd0);
    chk("single_busy", 32'(busy), 1);
    chk("single_dut_a_t0", 32'(dut_a), 0);
    step();
    chk("single_dut_a_t1", 32'(dut_a), 1);
    chk("single_dut_b_t1", 32'(dut_b), 1);
    chk("single_valid_t1", 32'(rsp_valid), 0);
    step();
    chk("single_valid_t2", 32'(rsp_valid), 1);
    get_rsp("single");
    chk("single_valid_after", 32'(rsp_valid), 0);
    chk("single_idle", 32'(busy), 0);

    // fill the FIFO behind a blocked response
    for (int i = 0; i < 5; i++) push(W'(i + 1), 4'hF, 4'd0);
    chk("full_ready_low", 32'(req_ready), 0);
    chk("full_drive", 32'(dut_a), 1);
    step(3);
    chk("full_ready_still_low", 32'(req_ready), 0);
    get_rsp("full0");
    chk("full_ready_at_hs", 32'(req_ready), 0);
    step();
    chk("full_ready_after_pop", 32'(req_ready), 1);
    for (int i = 1; i < 5; i++) get_rsp($sformatf("full%0d", i));
    step();
    chk("full_drained", 32'(exp_q.size()), 0);
    chk("full_idle", 32'(busy), 0);

    // stuck-at-0 output
    mode = 1;
    push(4'h1, 4'h1, 4'd0);
    push(4'h0, 4'h1, 4'd0);
    push(4'h1, 4'h1, 4'd0);
    for (int i = 0; i < 3; i++) get_rsp($sformatf("fault%0d", i));
    chk("fault_count", 32'(mismatch_count), 32'(exp_count));
    chk("fault_count_two", 32'(mismatch_count), 2);
    mode = 0;

    // backpressure with extra hold, then spacing to the next drive
    push(4'h1, 4'h0, 4'd3);
    step(4);
    chk("bp_valid_t4", 32'(rsp_valid), 0);
    step();
    chk("bp_valid_t5", 32'(rsp_valid), 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) push(4'h2, 4'h3, 4'd0);
      else step();
      chk($sformatf("bp_stable_v%0d", k), 32'(rsp_valid), 1);
      chk($sformatf("bp_stable_a%0d", k), 32'(rsp_a), 1);
      chk($sformatf("bp_stable_b%0d", k), 32'(rsp_b), 0);
      chk($sformatf("bp_stable_y%0d", k), 32'(rsp_y), 0);
    end
    get_rsp("bp");
    chk("bp_hold_drive", 32'(dut_a), 1);
    step();
    chk("bp_next_a", 32'(dut_a), 2);
    chk("bp_next_b", 32'(dut_b), 3);
    get_rsp("bp_next");

    // reset in the middle of a long drive with three entries queued
    mode = 1;
    for (int i = 0; i < 4; i++) push(W'(i + 5), W'(i + 5), 4'd15);
    chk("mid_state", 32'(state_dbg), 32'(DRIVE));
    step(2);
    reset = 1'b1;
    #1;
    chk("mid_rst_dut_a", 32'(dut_a), 0);
    chk("mid_rst_dut_b", 32'(dut_b), 0);
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ready", 32'(req_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_count", 32'(mismatch_count), 0);
    exp_q.delete();
    exp_count = '0;
    step();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid || dut_a != '0 || busy) bad++;
    end
    chk("mid_no_response", 32'(bad), 0);
    mode = 0;

    // randomized traffic with a partially faulty gate
    mode = 2;
    pushed = 0;
    for (int cyc = 0; cyc < 3000 && (pushed < 24 || exp_q.size() != 0); cyc++) begin
      if (!req_valid && pushed < 24 && $urandom_range(0, 1) == 1) begin
        req_valid = 1'b1;
        req_a = W'($urandom_range(0, 15));
        req_b = W'($urandom_range(0, 15));
        req_hold = HOLD_W'($urandom_range(0, 3));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      accepted = 0;
      if (req_valid && req_ready) begin
        exp_q.push_back(make_exp(req_a, req_b));
        pushed++;
        accepted = 1;
      end
      if (rsp_valid && rsp_ready) check_rsp("rand");
      step();
      if (accepted != 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rand_pushed", 32'(pushed), 24);
    chk("rand_drained", 32'(exp_q.size()), 0);
    chk("rand_count", 32'(mismatch_count), 32'(exp_count));
    mode = 0;

    // saturation from a preloaded counter
    step(2);
    force dut.mismatch_count = 16'hFFFE;
    #1;
    release dut.mismatch_count;
    exp_count = 16'hFFFE;
    step();
    chk("sat_preload", 32'(mismatch_count), 32'hFFFE);
    mode = 1;
    push(4'hF, 4'hF, 4'd0);
    push(4'h3, 4'h1, 4'd0);
    get_rsp("sat0");
    chk("sat_first", 32'(mismatch_count), 32'hFFFF);
    get_rsp("sat1");
    chk("sat_hold", 32'(mismatch_count), 32'hFFFF);
    chk("sat_model", 32'(mismatch_count), 32'(exp_count));
    mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
